// File: rtl/encode_pkg.sv
// rtl/encode_pkg.sv - shared token types and code constants for encode_code
package encode_pkg;

  typedef enum logic [1:0] {
    TOK_LIT   = 2'd0,
    TOK_MATCH = 2'd1,
    TOK_END   = 2'd2,
    TOK_RSVD  = 2'd3
  } tok_type_t;

  localparam int              CODE_W          = 13;
  localparam logic [CODE_W-1:0] END_CODE      = 13'h180;
  localparam logic [3:0]      END_LEN         = 4'd9;
  localparam int              SHORT_OFF_LIMIT = 128;

  localparam logic [1:0] LEN2_CODE    = 2'b00;
  localparam logic [1:0] LEN3_CODE    = 2'b01;
  localparam logic [1:0] LEN4_CODE    = 2'b10;
  localparam logic [3:0] LEN5_CODE    = 4'b1100;
  localparam logic [3:0] LEN6_CODE    = 4'b1101;
  localparam logic [3:0] LEN7_CODE    = 4'b1110;
  localparam logic [3:0] LEN_EXT_CODE = 4'b1111;

  // Returns {code_len, code} for a match offset.
  function automatic logic [CODE_W+3:0] off_code(input logic [10:0] off);
    if (off < 11'(SHORT_OFF_LIMIT))
      return {4'd9, 4'b0000, 2'b11, off[6:0]};
    return {4'd13, 2'b10, off};
  endfunction

endpackage

// File: rtl/encode_len_code.sv
// rtl/encode_len_code.sv - maps a match length to its short code, flags the extended case
module encode_len_code
  import encode_pkg::*;
#(
  parameter int LEN_W = 12
) (
  input  logic [LEN_W-1:0] len,
  output logic [3:0]       code,
  output logic [3:0]       code_len,
  output logic             ext
);

  always_comb begin
    code     = LEN_EXT_CODE;
    code_len = 4'd4;
    ext      = (len >= LEN_W'(8));
    if (!ext) begin
      case (len[2:0])
        3'd2:    begin code = {2'b00, LEN2_CODE}; code_len = 4'd2; end
        3'd3:    begin code = {2'b00, LEN3_CODE}; code_len = 4'd2; end
        3'd4:    begin code = {2'b00, LEN4_CODE}; code_len = 4'd2; end
        3'd5:    code = LEN5_CODE;
        3'd6:    code = LEN6_CODE;
        3'd7:    code = LEN7_CODE;
        default: begin code = 4'd0; code_len = 4'd0; end
      endcase
    end
  end

endmodule

// File: rtl/encode_code.sv
// rtl/encode_code.sv - LZS token to variable-length code encoder with end marker and word padding
module encode_code
  import encode_pkg::*;
#(
  parameter int LEN_W     = 12,
  parameter int WORD_BITS = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tok_valid,
  output logic             tok_ready,
  input  logic [1:0]       tok_type,
  input  logic [7:0]       tok_lit,
  input  logic [10:0]      tok_off,
  input  logic [LEN_W-1:0] tok_len,
  output logic [12:0]      cnt_output,
  output logic [3:0]       cnt_len,
  output logic             cnt_output_enable,
  output logic             cnt_finish,
  output logic             tok_err
);

  localparam int PW = $clog2(WORD_BITS);

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_EXT, S_PAD, S_FIN} state_t;

  state_t           state, state_n;
  logic [LEN_W-1:0] len_q, len_n, rem, rem_n;
  logic [PW-1:0]    pos, pad;
  logic [12:0]      out_n;
  logic [3:0]       olen_n;
  logic             en_n, err_n;
  logic [3:0]       lc_code, lc_len;
  logic             lc_ext;

  encode_len_code #(.LEN_W(LEN_W)) u_len_code (
    .len      (len_q),
    .code     (lc_code),
    .code_len (lc_len),
    .ext      (lc_ext)
  );

  assign tok_ready = (state == S_IDLE);
  // Bits still needed to reach the next word boundary; pos already includes the code on the bus.
  assign pad = PW'(0) - pos;

  always_comb begin
    state_n = state;
    len_n   = len_q;
    rem_n   = rem;
    out_n   = '0;
    olen_n  = '0;
    en_n    = 1'b0;
    err_n   = tok_err;
    case (state)
      S_IDLE: begin
        if (tok_valid) begin
          case (tok_type_t'(tok_type))
            TOK_LIT: begin
              out_n  = {5'd0, tok_lit};
              olen_n = 4'd9;
              en_n   = 1'b1;
            end
            TOK_MATCH: begin
              if (tok_len < LEN_W'(2) || tok_off == 11'd0) begin
                err_n = 1'b1;
              end else begin
                {olen_n, out_n} = off_code(tok_off);
                en_n    = 1'b1;
                len_n   = tok_len;
                state_n = S_LEN;
              end
            end
            TOK_END: begin
              out_n   = END_CODE;
              olen_n  = END_LEN;
              en_n    = 1'b1;
              state_n = S_PAD;
            end
            TOK_RSVD: err_n = 1'b1;
            default:  err_n = 1'b1;
          endcase
        end
      end
      S_LEN: begin
        out_n  = {9'd0, lc_code};
        olen_n = lc_len;
        en_n   = 1'b1;
        if (lc_ext) begin
          rem_n   = len_q - LEN_W'(8);
          state_n = S_EXT;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_EXT: begin
        olen_n = 4'd4;
        en_n   = 1'b1;
        if (rem >= LEN_W'(15)) begin
          out_n = {9'd0, LEN_EXT_CODE};
          rem_n = rem - LEN_W'(15);
        end else begin
          out_n   = {9'd0, rem[3:0]};
          state_n = S_IDLE;
        end
      end
      S_PAD: begin
        if (pad == '0) begin
          state_n = S_FIN;
        end else begin
          en_n   = 1'b1;
          olen_n = (pad > PW'(15)) ? 4'd15 : 4'(pad);
        end
      end
      S_FIN:   state_n = S_FIN;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= S_IDLE;
      len_q             <= '0;
      rem               <= '0;
      pos               <= '0;
      cnt_output        <= '0;
      cnt_len           <= '0;
      cnt_output_enable <= 1'b0;
      cnt_finish        <= 1'b0;
      tok_err           <= 1'b0;
    end else begin
      state             <= state_n;
      len_q             <= len_n;
      rem               <= rem_n;
      cnt_output        <= out_n;
      cnt_len           <= olen_n;
      cnt_output_enable <= en_n;
      cnt_finish        <= cnt_finish | (state_n == S_FIN);
      tok_err           <= err_n;
      if (en_n) pos <= pos + PW'(olen_n);
    end
  end

endmodule

// File: tb/tb_encode_code.sv
// tb/tb_encode_code.sv - randomized self-checking bench for encode_code
module tb_encode_code;

  localparam int LEN_W     = 12;
  localparam int WORD_BITS = 64;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             tok_valid = 1'b0;
  logic             tok_ready;
  logic [1:0]       tok_type = '0;
  logic [7:0]       tok_lit = '0;
  logic [10:0]      tok_off = '0;
  logic [LEN_W-1:0] tok_len = '0;
  logic [12:0]      cnt_output;
  logic [3:0]       cnt_len;
  logic             cnt_output_enable;
  logic             cnt_finish;
  logic             tok_err;

  always #5 clk = ~clk;

  encode_code #(.LEN_W(LEN_W), .WORD_BITS(WORD_BITS)) dut (
    .clk(clk), .rst(rst), .tok_valid(tok_valid), .tok_ready(tok_ready),
    .tok_type(tok_type), .tok_lit(tok_lit), .tok_off(tok_off), .tok_len(tok_len),
    .cnt_output(cnt_output), .cnt_len(cnt_len), .cnt_output_enable(cnt_output_enable),
    .cnt_finish(cnt_finish), .tok_err(tok_err)
  );

  int checks = 0;
  int failures = 0;
  logic [16:0] exp_q[$];
  logic [16:0] obs_q[$];
  int mbits = 0;
  bit merr = 1'b0;
  int idle_bad = 0;

  // Observed code stream, {len, code}
  always @(negedge clk) begin
    if (!rst && cnt_output_enable) obs_q.push_back({cnt_len, cnt_output});
    if (!rst && !cnt_output_enable && cnt_output !== 13'd0) idle_bad++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic push_exp(input int code, input int len);
    exp_q.push_back({4'(len), 13'(code)});
    mbits += len;
  endtask

  // Reference encoding straight from the code tables
  task automatic model_token(input int ty, input int lit, input int off, input int len);
    int r, p, n;
    if (ty == 3 || (ty == 1 && (len < 2 || off == 0))) begin
      merr = 1'b1;
    end else if (ty == 0) begin
      push_exp(lit, 9);
    end else if (ty == 1) begin
      if (off < 128) push_exp(384 + off, 9);
      else push_exp(4096 + off, 13);
      if (len <= 4) push_exp(len - 2, 2);
      else if (len <= 7) push_exp(12 + len - 5, 4);
      else begin
        push_exp(15, 4);
        r = len - 8;
        while (r >= 15) begin push_exp(15, 4); r -= 15; end
        push_exp(r, 4);
      end
    end else begin
      push_exp(384, 9);
      p = (WORD_BITS - (mbits % WORD_BITS)) % WORD_BITS;
      while (p > 0) begin
        n = (p > 15) ? 15 : p;
        push_exp(0, n);
        p -= n;
      end
    end
  endtask

  task automatic send(input int ty, input int lit, input int off, input int len);
    int n = 0;
    while (!tok_ready && n < 5000) begin @(negedge clk); n++; end
    if (!tok_ready) begin
      checks++; failures++;
      $display("FAIL send_timeout tok_ready=%0b required=1", tok_ready);
    end
    tok_valid = 1'b1;
    tok_type  = 2'(ty);
    tok_lit   = 8'(lit);
    tok_off   = 11'(off);
    tok_len   = LEN_W'(len);
    model_token(ty, lit, off, len);
    @(negedge clk);
    tok_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(tok_ready || cnt_finish) && n < 10000) begin @(negedge clk); n++; end
    if (!(tok_ready || cnt_finish)) begin
      checks++; failures++;
      $display("FAIL idle_timeout tok_ready=%0b cnt_finish=%0b", tok_ready, cnt_finish);
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tok_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    mbits = 0;
    merr = 1'b0;
  endtask

  task automatic rand_token(input bit allow_illegal);
    int sel = int'($urandom_range(0, 99));
    int off = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 127)) : int'($urandom_range(1, 2047));
    int lsel = int'($urandom_range(0, 3));
    int len = (lsel == 0) ? int'($urandom_range(2, 7)) :
              (lsel == 1) ? int'($urandom_range(8, 60)) :
              (lsel == 2) ? int'($urandom_range(61, 4095)) : int'($urandom_range(2, 30));
    if (sel < 50) send(0, int'($urandom_range(0, 255)), 0, 0);
    else if (sel < 95 || !allow_illegal) send(1, 0, off, len);
    else if (sel < 97) send(3, 0, off, len);
    else send(1, 0, off, int'($urandom_range(0, 1)));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tok_valid = 1'b1;
    tok_type = 2'd1; tok_off = 11'd9; tok_len = LEN_W'(40);
    @(negedge clk); @(negedge clk);
    checks++;
    if ({cnt_output, cnt_len, cnt_output_enable} !== 18'd0) begin
      failures++; $display("FAIL reset_outputs got=%h required=0", {cnt_output, cnt_len, cnt_output_enable});
    end
    checks++;
    if ({tok_ready, cnt_finish, tok_err} !== 3'b100) begin
      failures++; $display("FAIL reset_flags got=%b required=100", {tok_ready, cnt_finish, tok_err});
    end
    checks++;
    if (dut.pos !== '0) begin failures++; $display("FAIL reset_pos got=%0d required=0", dut.pos); end
    tok_valid = 1'b0;
    rst = 1'b0;
    exp_q.delete(); mbits = 0; merr = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_literal();
    logic [7:0] lits [3];
    tok_valid = 1'b1; tok_type = 2'd0; tok_lit = 8'h41;
    @(posedge clk); #1;
    tok_valid = 1'b0;
    checks++;
    if ({cnt_output, cnt_len, cnt_output_enable} !== {13'h041, 4'd9, 1'b1}) begin
      failures++; $display("FAIL lit_41 got=%h/%0d/%0b required=041/9/1", cnt_output, cnt_len, cnt_output_enable);
    end
    checks++;
    if (tok_ready !== 1'b1) begin failures++; $display("FAIL lit_ready got=%0b required=1", tok_ready); end
    @(negedge clk);
    for (int i = 0; i < 3; i++) lits[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin tok_valid = 1'b1; tok_type = 2'd0; tok_lit = lits[i]; end
      else tok_valid = 1'b0;
      if (i > 0) begin
        checks++;
        if ({cnt_output_enable, cnt_output} !== {1'b1, 5'd0, lits[i-1]}) begin
          failures++; $display("FAIL lit_b2b[%0d] got=%0b/%h required=1/%h", i-1, cnt_output_enable, cnt_output, lits[i-1]);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_match();
    int offs [7] = '{5, 5, 300, 300, 127, 128, 2047};
    int lens [7] = '{2, 5, 8, 23, 4, 7, 4095};
    int base = obs_q.size();
    exp_q.delete();
    for (int i = 0; i < 7; i++) begin
      send(1, 0, offs[i], lens[i]);
      checks++;
      if (tok_ready !== 1'b0) begin failures++; $display("FAIL match_busy[%0d] tok_ready=%0b required=0", i, tok_ready); end
      if (lens[i] < 8) begin
        @(negedge clk);
        checks++;
        if (tok_ready !== 1'b1) begin failures++; $display("FAIL match_ready[%0d] tok_ready=%0b required=1", i, tok_ready); end
      end
      wait_idle();
    end
    checks++;
    if (obs_q.size() - base !== exp_q.size()) begin
      failures++; $display("FAIL match_count got=%0d required=%0d", obs_q.size() - base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[base+i] !== exp_q[i]) begin
        failures++; $display("FAIL match_code[%0d] got=%h required=%h", i, obs_q[base+i], exp_q[i]);
      end
    end
  endtask

  task automatic test_illegal();
    int base = obs_q.size();
    exp_q.delete();
    checks++;
    if (tok_err !== merr) begin failures++; $display("FAIL err_initial got=%0b required=%0b", tok_err, merr); end
    send(1, 0, 5, 1);
    send(1, 0, 0, 10);
    send(3, 0, 5, 5);
    checks++;
    if ({tok_ready, cnt_output_enable} !== 2'b10) begin
      failures++; $display("FAIL err_idle got=%b required=10", {tok_ready, cnt_output_enable});
    end
    @(negedge clk);
    checks++;
    if (tok_err !== merr) begin failures++; $display("FAIL err_sticky got=%0b required=%0b", tok_err, merr); end
    send(0, 8'h5a, 0, 0);
    wait_idle();
    checks++;
    if (obs_q.size() - base !== exp_q.size()) begin
      failures++; $display("FAIL err_count got=%0d required=%0d", obs_q.size() - base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[base+i] !== exp_q[i]) begin
        failures++; $display("FAIL err_code[%0d] got=%h required=%h", i, obs_q[base+i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    int base;
    int bad0;
    do_reset();
    base = obs_q.size();
    bad0 = idle_bad;
    for (int i = 0; i < 80; i++) rand_token(1'b1);
    wait_idle();
    checks++;
    if (obs_q.size() - base !== exp_q.size()) begin
      failures++; $display("FAIL rand_count got=%0d required=%0d", obs_q.size() - base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[base+i] !== exp_q[i]) begin
        failures++; $display("FAIL rand_code[%0d] got=%h required=%h", i, obs_q[base+i], exp_q[i]);
      end
    end
    checks++;
    if (idle_bad !== bad0) begin failures++; $display("FAIL rand_idle_zero got=%0d required=%0d", idle_bad, bad0); end
    checks++;
    if (tok_err !== merr) begin failures++; $display("FAIL rand_err got=%0b required=%0b", tok_err, merr); end
  endtask

  task automatic test_reset_mid();
    int base;
    do_reset();
    send(1, 0, 300, 4095);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({cnt_output, cnt_len, cnt_output_enable, cnt_finish, tok_err, tok_ready} !== {21'd0, 1'b1}) begin
      failures++; $display("FAIL rst_ext got=%h/%0d/%0b ready=%0b required=0/0/0 ready=1",
                           cnt_output, cnt_len, cnt_output_enable, tok_ready);
    end
    checks++;
    if (dut.pos !== '0) begin failures++; $display("FAIL rst_ext_pos got=%0d required=0", dut.pos); end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (cnt_output_enable !== 1'b0) begin failures++; $display("FAIL rst_ext_partial got=%0b required=0", cnt_output_enable); end
    send(2, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({tok_ready, cnt_finish, cnt_output_enable} !== 3'b100) begin
      failures++; $display("FAIL rst_pad got=%b required=100", {tok_ready, cnt_finish, cnt_output_enable});
    end
    exp_q.delete(); mbits = 0; merr = 1'b0;
    base = obs_q.size();
    send(0, 8'h7e, 0, 0);
    wait_idle();
    checks++;
    if (obs_q.size() - base !== 1 || obs_q[base] !== exp_q[0]) begin
      failures++; $display("FAIL rst_after_lit got=%h count=%0d required=%h", obs_q[obs_q.size()-1], obs_q.size() - base, exp_q[0]);
    end
  endtask

  task automatic test_end();
    int base;
    int nobs;
    do_reset();
    base = obs_q.size();
    send(0, 8'h41, 0, 0);
    send(2, 0, 0, 0);
    checks++;
    if ({cnt_output, cnt_len} !== {13'h180, 4'd9} || dut.pos !== 6'(18)) begin
      failures++; $display("FAIL end_marker got=%h/%0d pos=%0d required=180/9 pos=18", cnt_output, cnt_len, dut.pos);
    end
    wait_idle();
    checks++;
    if (obs_q.size() - base !== exp_q.size()) begin
      failures++; $display("FAIL end_count got=%0d required=%0d", obs_q.size() - base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[base+i] !== exp_q[i]) begin
        failures++; $display("FAIL end_code[%0d] got=%h required=%h", i, obs_q[base+i], exp_q[i]);
      end
    end
    nobs = obs_q.size();
    tok_valid = 1'b1; tok_type = 2'd0; tok_lit = 8'h33;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({cnt_finish, tok_ready, cnt_output_enable} !== 3'b100) begin
        failures++; $display("FAIL end_fin_hold[%0d] got=%b required=100", i, {cnt_finish, tok_ready, cnt_output_enable});
      end
      @(negedge clk);
    end
    tok_valid = 1'b0;
    checks++;
    if (obs_q.size() !== nobs || dut.pos !== '0) begin
      failures++; $display("FAIL end_fin_quiet codes=%0d pos=%0d required=%0d pos=0", obs_q.size(), dut.pos, nobs);
    end
  endtask

  task automatic test_end_random();
    int base;
    do_reset();
    base = obs_q.size();
    for (int i = 0; i < 25; i++) rand_token(1'b0);
    send(2, 0, 0, 0);
    wait_idle();
    checks++;
    if (obs_q.size() - base !== exp_q.size()) begin
      failures++; $display("FAIL endr_count got=%0d required=%0d", obs_q.size() - base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[base+i] !== exp_q[i]) begin
        failures++; $display("FAIL endr_code[%0d] got=%h required=%h", i, obs_q[base+i], exp_q[i]);
      end
    end
    checks++;
    if ({cnt_finish, tok_ready} !== 2'b10 || dut.pos !== '0) begin
      failures++; $display("FAIL endr_fin got=%b pos=%0d required=10 pos=0", {cnt_finish, tok_ready}, dut.pos);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_literal();
    test_match();
    test_illegal();
    test_random();
    test_reset_mid();
    test_end();
    test_end_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
